aes_sub_bytes_seq: RTL and testbench

//  Initiator side of the byte-wide S-box request interface: applies SubBytes or InvSubBytes
//  to a 128-bit AES state by issuing one S-box lookup per byte through a single shared S-box.

---
 rtl/aes_sub_bytes_seq.sv | 117 +++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_seq.sv
// Byte-serial SubBytes / InvSubBytes engine: feeds one state byte per cycle through a
// single shared external S-box and collects the responses into a 128-bit result register.
module aes_sub_bytes_seq #(
  parameter int NUM_BYTES = 16,
  parameter int SBOX_LAT  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             in_op_i,
  input  logic [8*NUM_BYTES-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [8*NUM_BYTES-1:0] out_data_o,
  output logic                   busy_o,
  output logic [9:0]             sbox_req_o,
  input  logic [7:0]             sbox_rsp_i,
  output logic [1:0]             state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_valid_o/out_data_o hold until the transfer.

  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_NUM  = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [8*NUM_BYTES-1:0] data_q;
  logic [8*NUM_BYTES-1:0] res_q;
  logic [1:0]             op_q;
  logic [CNT_W-1:0]       req_cnt_q, rsp_cnt_q;
  logic                   accept, req_fire, rsp_fire, rsp_last;
  logic [7:0]             req_byte;

  assign accept   = in_valid_i && (state_q == IDLE);
  assign req_fire = (state_q == RUN) && (req_cnt_q < CNT_NUM);
  assign rsp_last = rsp_fire && (rsp_cnt_q == CNT_LAST);

  // A response is due SBOX_LAT cycles after its request was driven.
  generate
    if (SBOX_LAT == 0) begin : g_comb_rsp
      assign rsp_fire = req_fire;
    end else begin : g_reg_rsp
      logic [SBOX_LAT-1:0] pend_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pend_q <= '0;
        end else begin
          pend_q[0] <= req_fire;
          for (int i = 1; i < SBOX_LAT; i++) pend_q[i] <= pend_q[i-1];
        end
      end
      assign rsp_fire = pend_q[SBOX_LAT-1];
    end
  endgenerate

  always_comb begin
    req_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (req_cnt_q == CNT_W'(i)) req_byte = data_q[8*i +: 8];
    end
  end

  assign sbox_req_o = req_fire ? {req_byte, op_q} : 10'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (rsp_last) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      op_q      <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      res_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q    <= in_data_i;
        op_q      <= in_op_i;
        req_cnt_q <= '0;
        rsp_cnt_q <= '0;
      end
      if (req_fire) req_cnt_q <= req_cnt_q + CNT_ONE;
      if (rsp_fire) begin
        rsp_cnt_q <= rsp_cnt_q + CNT_ONE;
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (rsp_cnt_q == CNT_W'(i)) res_q[8*i +: 8] <= sbox_rsp_i;
        end
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign out_data_o  = res_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: unit 0 uses a combinational S-box (SBOX_LAT=0), unit 1 a
// registered one (SBOX_LAT=1); a cycle-level job model is checked every cycle.
module tb_aes_sub_bytes_seq;
  localparam int NB = 16;
  localparam int W  = 8 * NB;
  localparam logic [W-1:0] APPB_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [W-1:0] APPB_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2], in_valid[2], out_ready[2];
  logic [1:0]   in_op[2];
  logic [W-1:0] in_data[2];
  logic         in_ready[2], out_valid[2], busy[2];
  logic [W-1:0] out_data[2];
  logic [9:0]   sbox_req[2];
  logic [1:0]   state_dbg[2];
  logic [7:0]   sbox_rsp0, sbox_rsp1;

  int checks = 0;
  int failures = 0;

  aes_sub_bytes_seq #(.NUM_BYTES(NB), .SBOX_LAT(0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_op_i(in_op[0]), .in_data_i(in_data[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_data_o(out_data[0]), .busy_o(busy[0]),
    .sbox_req_o(sbox_req[0]), .sbox_rsp_i(sbox_rsp0), .state_o(state_dbg[0])
  );

  aes_sub_bytes_seq #(.NUM_BYTES(NB), .SBOX_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_op_i(in_op[1]), .in_data_i(in_data[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_data_o(out_data[1]), .busy_o(busy[1]),
    .sbox_req_o(sbox_req[1]), .sbox_rsp_i(sbox_rsp1), .state_o(state_dbg[1])
  );

  // ---------------- GF(2^8) S-box model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int x = 1; x < 256; x++) if (gmul(a, 8'(x)) == 8'h01) r = 8'(x);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_lookup(input logic [9:0] req);
    logic [7:0] b, s;
    b = req[9:2];
    if (req[1:0] == 2'b10) begin
      s = rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
      return ginv(s);
    end
    s = ginv(b);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [W-1:0] sub_state(input logic [W-1:0] d, input logic [1:0] op);
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = sbox_lookup({d[8*i +: 8], op});
    return r;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 0 : 1;
  endfunction

  always_comb sbox_rsp0 = sbox_lookup(sbox_req[0]);
  always @(posedge clk) sbox_rsp1 <= sbox_lookup(sbox_req[1]);

  task automatic chk(input int u, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL u%0d %s actual=%h required=%h", u, name, act, exp);
    end
  endtask

  // ---------------- job-level model and scoreboard ----------------
  logic         m_active[2];
  int           m_t[2];
  logic [W-1:0] m_din[2], m_res[2], m_old[2], m_popped[2];
  logic [1:0]   m_op[2];
  int           m_done_n[2]   = '{0, 0};
  int           m_done_chk[2] = '{0, 0};
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Model advances on the edge using only bench-driven inputs and its own state.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        m_active[u] = 1'b0;
        m_t[u] = 0;
        m_old[u] = '0;
        if (u == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (!m_active[u]) begin
        if (in_valid[u]) begin
          m_active[u] = 1'b1;
          m_t[u] = 0;
          m_din[u] = in_data[u];
          m_op[u] = in_op[u];
          m_res[u] = sub_state(in_data[u], in_op[u]);
          if (u == 0) exp_q0.push_back(m_res[u]); else exp_q1.push_back(m_res[u]);
        end
      end else if (m_t[u] >= NB + lat_of(u) && out_ready[u]) begin
        m_active[u] = 1'b0;
        m_old[u] = m_res[u];
        if (u == 0 && exp_q0.size() > 0) m_popped[0] = exp_q0.pop_front();
        if (u == 1 && exp_q1.size() > 0) m_popped[1] = exp_q1.pop_front();
        m_done_n[u]++;
      end else begin
        m_t[u]++;
      end
    end
  end

  logic [W-1:0] e_data;
  logic [9:0]   e_req;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      e_req = 10'd0;
      if (m_active[u] && m_t[u] < NB) e_req = {m_din[u][8*m_t[u] +: 8], m_op[u]};
      for (int i = 0; i < NB; i++) begin
        if (m_active[u] && i < m_t[u] - lat_of(u)) e_data[8*i +: 8] = m_res[u][8*i +: 8];
        else e_data[8*i +: 8] = m_old[u][8*i +: 8];
      end
      chk(u, "mon_in_ready", in_ready[u], !m_active[u]);
      chk(u, "mon_busy", busy[u], m_active[u]);
      chk(u, "mon_out_valid", out_valid[u], m_active[u] && m_t[u] >= NB + lat_of(u));
      chk(u, "mon_sbox_req", sbox_req[u], e_req);
      chk(u, "mon_out_data", out_data[u], e_data);
      if (m_done_n[u] != m_done_chk[u]) begin
        chk(u, "sb_result", out_data[u], m_popped[u]);
        m_done_chk[u] = m_done_n[u];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input int u, input logic [W-1:0] d, input logic [1:0] op, input int hold,
                         output logic [W-1:0] res, output int lat, output int ninv);
    int n;
    logic [W-1:0] first;
    res = '0; lat = 0; ninv = 0; n = 0;
    @(negedge clk);
    in_valid[u] = 1'b1; in_data[u] = d; in_op[u] = op; out_ready[u] = (hold < 0);
    while (!in_ready[u] && n < 50) begin @(negedge clk); n++; end
    chk(u, "accept_timeout", n < 50, 1'b1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u] = {$urandom, $urandom, $urandom, $urandom};
    in_op[u] = 2'($urandom_range(0, 3));
    while (!out_valid[u] && lat < 100) begin
      if (sbox_req[u][1:0] == 2'b10) ninv++;
      @(negedge clk);
      lat++;
    end
    chk(u, "done_timeout", lat < 100, 1'b1);
    first = out_data[u];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk(u, "stall_valid", out_valid[u], 1'b1);
      chk(u, "stall_data", out_data[u], first);
      chk(u, "stall_in_ready", in_ready[u], 1'b0);
    end
    res = out_data[u];
    out_ready[u] = 1'b1;
    @(negedge clk);
    chk(u, "post_handshake_valid", out_valid[u], 1'b0);
    chk(u, "post_handshake_ready", in_ready[u], 1'b1);
    out_ready[u] = 1'b0;
  endtask

  task automatic abort_job(input int u, input logic [W-1:0] d, input logic [1:0] op, input int at);
    int n;
    n = 0;
    @(negedge clk);
    in_valid[u] = 1'b1; in_data[u] = d; in_op[u] = op; out_ready[u] = 1'b0;
    while (!in_ready[u] && n < 50) begin @(negedge clk); n++; end
    chk(u, "abort_accept_timeout", n < 50, 1'b1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    repeat (at) @(negedge clk);
    if (at < NB) chk(u, "abort_req_byte", sbox_req[u], {d[8*at +: 8], op});
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    chk(u, "abort_in_ready", in_ready[u], 1'b1);
    chk(u, "abort_out_valid", out_valid[u], 1'b0);
    chk(u, "abort_busy", busy[u], 1'b0);
    chk(u, "abort_out_data", out_data[u], '0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] res, d;
    logic [1:0]   op;
    int           lat, ninv;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_valid[u] = 1'b0; out_ready[u] = 1'b0; in_op[u] = 2'b00; in_data[u] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk(u, "reset_in_ready", in_ready[u], 1'b1);
      chk(u, "reset_out_valid", out_valid[u], 1'b0);
      chk(u, "reset_busy", busy[u], 1'b0);
      chk(u, "reset_out_data", out_data[u], '0);
      chk(u, "reset_sbox_req", sbox_req[u], 10'd0);
    end

    chk(0, "model_fwd_00", sbox_lookup({8'h00, 2'b01}), 8'h63);
    chk(0, "model_fwd_53", sbox_lookup({8'h53, 2'b01}), 8'hed);
    chk(0, "model_inv_63", sbox_lookup({8'h63, 2'b10}), 8'h00);
    chk(0, "model_appb", sub_state(APPB_IN, 2'b01), APPB_OUT);

    run_job(0, '0, 2'b01, -1, res, lat, ninv);
    chk(0, "t1_result", res, {NB{8'h63}});
    chk(0, "t1_latency", lat, 16);

    run_job(0, APPB_IN, 2'b01, 0, res, lat, ninv);
    chk(0, "t2_result", res, APPB_OUT);

    run_job(0, APPB_OUT, 2'b10, 0, res, lat, ninv);
    chk(0, "t3_result", res, APPB_IN);
    chk(0, "t3_inv_req_cycles", ninv, 16);

    d = {$urandom, $urandom, $urandom, $urandom};
    run_job(0, d, 2'b01, 5, res, lat, ninv);
    chk(0, "t4_result", res, sub_state(d, 2'b01));

    abort_job(0, {$urandom, $urandom, $urandom, $urandom}, 2'b01, 7);
    run_job(0, {NB{8'h53}}, 2'b01, 0, res, lat, ninv);
    chk(0, "t5_result", res, {NB{8'hed}});

    run_job(1, APPB_IN, 2'b01, 0, res, lat, ninv);
    chk(1, "t6_result", res, APPB_OUT);
    chk(1, "t6_latency", lat, 17);

    run_job(0, APPB_IN, 2'b00, 0, res, lat, ninv);
    chk(0, "op00_result", res, APPB_OUT);
    run_job(1, APPB_IN, 2'b11, 0, res, lat, ninv);
    chk(1, "op11_result", res, APPB_OUT);

    for (int u = 0; u < 2; u++) begin
      for (int j = 0; j < 20; j++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) begin
          abort_job(u, d, op, $urandom_range(0, NB + lat_of(u)));
        end else begin
          run_job(u, d, op, $urandom_range(0, 3) - 1, res, lat, ninv);
          chk(u, "rand_result", res, sub_state(d, op));
          chk(u, "rand_latency", lat, NB + lat_of(u));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    chk(0, "exp_q_drained", exp_q0.size(), 0);
    chk(1, "exp_q_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
